program_sequencer: RTL and testbench



---
 rtl/program_sequencer.sv | 130 +++++++++++++
 tb/tb_program_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program sequencer: parametrised PC with an internal return stack.
// Feeds the instruction ROM address port from decode-side commands.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall             hold PC, stack and flags this cycle
//   jmp / call / ret_f absolute jump, call (push + jump), return (pop)
//   br, cond          relative branch, taken only when both are high
//   tgt_addr          absolute target for jmp/call
//   br_offs           signed relative-branch offset
//   data_out          current PC (registered)
//   sp                number of valid return-stack entries (registered)
//   ovf / unf         sticky call-on-full / return-on-empty flags
module program_sequencer #(
    parameter int CNTR_WIDTH  = 8,
    parameter int OFFS_WIDTH  = 6,
    parameter int STACK_DEPTH = 4,
    parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1),
    parameter int RESET_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  jmp,
    input  logic                  call,
    input  logic                  ret_f,
    input  logic                  br,
    input  logic                  cond,
    input  logic [CNTR_WIDTH-1:0] tgt_addr,
    input  logic [OFFS_WIDTH-1:0] br_offs,
    output logic [CNTR_WIDTH-1:0] data_out,
    output logic [SP_WIDTH-1:0]   sp,
    output logic                  ovf,
    output logic                  unf
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [CNTR_WIDTH-1:0] pc_q, pc_d;
    logic [SP_WIDTH-1:0]   sp_q, sp_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [CNTR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [CNTR_WIDTH-1:0] pc_inc;
    logic [CNTR_WIDTH-1:0] offs_ext;
    logic [IDX_W-1:0]      top_idx;
    logic [IDX_W-1:0]      push_idx;
    logic                  stk_full;
    logic                  stk_empty;
    logic                  push_en;

    assign pc_inc    = pc_q + CNTR_WIDTH'(1);
    // Signed size cast sign-extends the offset to the PC width.
    assign offs_ext  = CNTR_WIDTH'($signed(br_offs));
    // Top index wraps harmlessly when empty; it is only used when sp>0.
    assign top_idx   = IDX_W'(sp_q - SP_WIDTH'(1));
    assign push_idx  = IDX_W'(sp_q);
    assign stk_full  = (sp_q == SP_WIDTH'(STACK_DEPTH));
    assign stk_empty = (sp_q == '0);

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        priority case (1'b1)
            stall: begin
                pc_d = pc_q;
            end
            ret_f: begin
                if (!stk_empty) begin
                    pc_d = stack_q[top_idx];
                    sp_d = sp_q - SP_WIDTH'(1);
                end else begin
                    // Return on empty acts as a no-op instruction.
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end
            call: begin
                pc_d = tgt_addr;
                if (!stk_full) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_WIDTH'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            jmp: begin
                pc_d = tgt_addr;
            end
            (br && cond): begin
                pc_d = pc_q + offs_ext;
            end
            default: begin
                pc_d = pc_inc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= CNTR_WIDTH'(RESET_ADDR);
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents need no reset; occupancy is tracked by sp_q.
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign data_out = pc_q;
    assign sp       = sp_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer.
// Directed vectors checked against a queue-based model and literals.
module tb_program_sequencer;

    localparam int CW    = 8;
    localparam int OW    = 6;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int RST_A = 0;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          jmp;
    logic          call;
    logic          ret_f;
    logic          br;
    logic          cond;
    logic [CW-1:0] tgt_addr;
    logic [OW-1:0] br_offs;
    logic [CW-1:0] data_out;
    logic [SPW-1:0] sp;
    logic          ovf;
    logic          unf;

    int n_checks = 0;
    int n_fail   = 0;

    program_sequencer #(
        .CNTR_WIDTH (CW),
        .OFFS_WIDTH (OW),
        .STACK_DEPTH(DEPTH),
        .SP_WIDTH   (SPW),
        .RESET_ADDR (RST_A)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .jmp     (jmp),
        .call    (call),
        .ret_f   (ret_f),
        .br      (br),
        .cond    (cond),
        .tgt_addr(tgt_addr),
        .br_offs (br_offs),
        .data_out(data_out),
        .sp      (sp),
        .ovf     (ovf),
        .unf     (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: PC as an integer, stack as a queue.
    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int o;
        if (!rst_n) begin
            m_pc = RST_A;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && !stall) begin
            if (ret_f) begin
                if (m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
                    m_unf = 1'b1;
                    m_pc = (m_pc + 1) % 256;
                end
            end else if (call) begin
                if (m_stk.size() < DEPTH)
                    m_stk.push_back((m_pc + 1) % 256);
                else
                    m_ovf = 1'b1;
                m_pc = int'(tgt_addr);
            end else if (jmp) begin
                m_pc = int'(tgt_addr);
            end else if (br && cond) begin
                o = int'(br_offs);
                if (br_offs[OW-1]) o = o - 64;
                m_pc = (m_pc + o + 256) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("model_pc", int'(data_out), m_pc);
            check("model_sp", int'(sp), m_stk.size());
            check("model_ovf", int'(ovf), int'(m_ovf));
            check("model_unf", int'(unf), int'(m_unf));
        end
    end

    // Inputs change 2 units after the edge, after the compare.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        stall = 0; jmp = 0; call = 0; ret_f = 0;
        br = 0; cond = 0; tgt_addr = '0; br_offs = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        check("rst_pc", int'(data_out), RST_A);
        check("rst_sp", int'(sp), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_unf", int'(unf), 0);
        rst_n = 1'b1;

        // Free-running count with wrap.
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 255) check("cnt_255", int'(data_out), 255);
            if (i == 256) check("cnt_wrap", int'(data_out), 0);
        end
        check("cnt_300", int'(data_out), 44);

        // Single call / return.
        jmp = 1; tgt_addr = 8'h10; tick();
        check("jmp_10", int'(data_out), 'h10);
        jmp = 0; call = 1; tgt_addr = 8'h40; tick();
        check("call_pc", int'(data_out), 'h40);
        check("call_sp", int'(sp), 1);
        idle(); tick(); tick(); tick();
        ret_f = 1; tick();
        check("ret_pc", int'(data_out), 'h11);
        check("ret_sp", int'(sp), 0);
        idle();

        // Nested calls past the stack depth.
        call = 1;
        tgt_addr = 8'h20; tick();
        tgt_addr = 8'h30; tick();
        tgt_addr = 8'h40; tick();
        tgt_addr = 8'h50; tick();
        tgt_addr = 8'h60; tick();
        check("ovf_pc", int'(data_out), 'h60);
        check("ovf_sp", int'(sp), 4);
        check("ovf_flag", int'(ovf), 1);
        idle(); ret_f = 1;
        tick(); check("pop1", int'(data_out), 'h41);
        tick(); check("pop2", int'(data_out), 'h31);
        tick(); check("pop3", int'(data_out), 'h21);
        tick(); check("pop4", int'(data_out), 'h12);
        tick();
        check("unf_pc", int'(data_out), 'h13);
        check("unf_flag", int'(unf), 1);
        check("unf_sp", int'(sp), 0);
        idle();

        // Relative branches with wrap both ways.
        jmp = 1; tgt_addr = 8'h05; tick();
        idle(); br = 1; cond = 1; br_offs = 6'b111000; tick();
        check("br_neg", int'(data_out), 'hFD);
        cond = 0; tick();
        check("br_nt", int'(data_out), 'hFE);
        cond = 1; br_offs = 6'd3; tick();
        check("br_pos", int'(data_out), 'h01);
        idle();

        // Simultaneous requests.
        call = 1; tgt_addr = 8'h80; tick();
        stall = 1; ret_f = 1; call = 1; tgt_addr = 8'h90; tick();
        check("stall_pc", int'(data_out), 'h80);
        check("stall_sp", int'(sp), 1);
        stall = 0; tick();
        check("retcall_pc", int'(data_out), 'h02);
        check("retcall_sp", int'(sp), 0);
        idle(); call = 1; jmp = 1; tgt_addr = 8'hA0; tick();
        check("calljmp_pc", int'(data_out), 'hA0);
        check("calljmp_sp", int'(sp), 1);
        idle(); jmp = 1; br = 1; cond = 1; br_offs = 6'd3;
        tgt_addr = 8'hB0; tick();
        check("jmpbr_pc", int'(data_out), 'hB0);
        idle();

        // Reset overrides a call; reset released during stall.
        call = 1; tgt_addr = 8'hC0; tick();
        tgt_addr = 8'hD0; tick();
        check("pre_sp", int'(sp), 3);
        check("pre_ovf", int'(ovf), 1);
        rst_n = 0; tgt_addr = 8'hE0; tick();
        check("rst2_pc", int'(data_out), RST_A);
        check("rst2_sp", int'(sp), 0);
        check("rst2_ovf", int'(ovf), 0);
        check("rst2_unf", int'(unf), 0);
        call = 0; stall = 1; tick();
        rst_n = 1; tick();
        check("hold1", int'(data_out), RST_A);
        tick();
        check("hold2", int'(data_out), RST_A);
        stall = 0; tick();
        check("run1", int'(data_out), RST_A + 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
